// File: rtl/internal_bus_loader.sv
// internal_bus_loader: drive/load side of the 8-bit internal bus.
// Takes one transfer request (source index + destination mask). It enables
// exactly one bus source for two cycles. On the second cycle it latches the
// settled bus byte into every selected destination register.
//
// state | meaning
// IDLE  | ready for a request; no source driving the bus
// DRIVE | selected source enabled; bus settling, value ignored
// LATCH | source still enabled; bus byte written to selected regs at cycle end
// DONE  | source released; done pulse; back to IDLE next cycle
module internal_bus_loader #(
    parameter int  INPUT_COUNT  = 4,
    parameter int  OUTPUT_COUNT = 4,
    localparam int SRC_W        = $clog2(INPUT_COUNT) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [SRC_W-1:0]          i_req_src,
    input  logic [OUTPUT_COUNT-1:0]   i_req_dst,
    output logic [INPUT_COUNT-1:0]    o_src_enable,
    input  logic [7:0]                i_bus_value,
    output logic [8*OUTPUT_COUNT-1:0] o_reg_outputs,
    output logic                      o_done,
    output logic                      o_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [SRC_W-1:0] SRC_LIMIT = SRC_W'(INPUT_COUNT);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [SRC_W-1:0]            r_src;
    logic [OUTPUT_COUNT-1:0]     r_dst;
    logic [8*OUTPUT_COUNT-1:0]   r_regs;
    logic                        r_err;
    logic                        w_accept;
    logic                        w_req_ok;
    logic [INPUT_COUNT-1:0]      w_src_enable;

    assign w_accept = i_req_valid && (r_state == ST_IDLE);
    assign w_req_ok = (i_req_src < SRC_LIMIT) && (|i_req_dst);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a rejected request leaves the FSM in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_req_ok) w_state_next = ST_DRIVE;
            ST_DRIVE: w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Capture the request at accept so the requester's inputs become don't-care.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src <= '0;
            r_dst <= '0;
        end else if (w_accept && w_req_ok) begin
            r_src <= i_req_src;
            r_dst <= i_req_dst;
        end
    end

    // Err pulses in the cycle after a rejected accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_req_ok;
        end
    end

    // Destination registers load only at the LATCH cycle-end edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= '0;
        end else if (r_state == ST_LATCH) begin
            for (int k = 0; k < OUTPUT_COUNT; k++) begin
                if (r_dst[k]) begin
                    r_regs[8*k +: 8] <= i_bus_value;
                end
            end
        end
    end

    // One-hot source enable, only while DRIVE or LATCH; r_src was range-checked.
    always_comb begin
        w_src_enable = '0;
        if ((r_state == ST_DRIVE) || (r_state == ST_LATCH)) begin
            for (int i = 0; i < INPUT_COUNT; i++) begin
                if (r_src == SRC_W'(i)) begin
                    w_src_enable[i] = 1'b1;
                end
            end
        end
    end

    assign o_src_enable  = w_src_enable;
    assign o_req_ready   = (r_state == ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_err         = r_err;
    assign o_reg_outputs = r_regs;

endmodule

// File: tb/tb_internal_bus_loader.sv
// Scoreboard bench for internal_bus_loader: stimulus pushes the expected
// outcome of each request; a monitor pops on every done/err pulse.
module tb_internal_bus_loader;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_src;
    logic [3:0]  i_req_dst;
    logic [3:0]  o_src_enable;
    logic [7:0]  i_bus_value;
    logic [31:0] o_reg_outputs;
    logic        o_done;
    logic        o_err;

    typedef struct packed {
        logic        is_err;
        logic [31:0] regs;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_regs;
    int          checks;
    int          errors;

    internal_bus_loader dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_src     (i_req_src),
        .i_req_dst     (i_req_dst),
        .o_src_enable  (o_src_enable),
        .i_bus_value   (i_bus_value),
        .o_reg_outputs (o_reg_outputs),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] apply_load(input logic [31:0] regs, input logic [3:0] dst,
                                               input logic [7:0] val);
        logic [31:0] r;
        r = regs;
        for (int k = 0; k < 4; k++) begin
            if (dst[k]) r[8*k +: 8] = val;
        end
        return r;
    endfunction

    // Monitor: every done/err pulse consumes one expected outcome.
    always @(negedge clk) begin
        exp_t e;
        if (o_done && o_err) begin
            checks++;
            errors++;
            $display("FAIL done_err_together actual=1 required=0");
        end
        if (o_done || o_err) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse done=%0b err=%0b required=none", o_done, o_err);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_kind_err", {31'd0, o_err}, {31'd0, e.is_err});
                chk("regs_at_pulse", o_reg_outputs, e.regs);
            end
        end
    end

    // Full transfer; called at a negedge while the DUT is idle.
    task automatic do_xfer(input logic [2:0] src, input logic [3:0] dst,
                           input logic [7:0] bus_drive, input logic [7:0] bus_latch,
                           input logic [3:0] exp_en);
        exp_t e;
        chk("ready_before_req", {31'd0, o_req_ready}, 32'd1);
        model_regs = apply_load(model_regs, dst, bus_latch);
        e.is_err = 1'b0;
        e.regs   = model_regs;
        sb_q.push_back(e);
        i_req_valid = 1'b1;
        i_req_src   = src;
        i_req_dst   = dst;
        i_bus_value = bus_drive;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_src   = 3'd5;
        i_req_dst   = 4'd0;
        @(negedge clk);
        chk("src_enable_drive", {28'd0, o_src_enable}, {28'd0, exp_en});
        chk("ready_in_drive", {31'd0, o_req_ready}, 32'd0);
        @(posedge clk); #1;
        i_bus_value = bus_latch;
        @(negedge clk);
        chk("src_enable_latch", {28'd0, o_src_enable}, {28'd0, exp_en});
        @(posedge clk); #1;
        i_bus_value = 8'h00;
        @(negedge clk);
        chk("done_at_t3", {31'd0, o_done}, 32'd1);
        chk("src_enable_done", {28'd0, o_src_enable}, 32'd0);
        @(negedge clk);
        chk("ready_at_t4", {31'd0, o_req_ready}, 32'd1);
    endtask

    // Rejected request; called at a negedge while idle.
    task automatic do_reject(input logic [2:0] src, input logic [3:0] dst);
        exp_t e;
        e.is_err = 1'b1;
        e.regs   = model_regs;
        sb_q.push_back(e);
        i_req_valid = 1'b1;
        i_req_src   = src;
        i_req_dst   = dst;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        chk("err_at_t1", {31'd0, o_err}, 32'd1);
        chk("reject_ready", {31'd0, o_req_ready}, 32'd1);
        chk("reject_src_enable", {28'd0, o_src_enable}, 32'd0);
        @(negedge clk);
        chk("err_single_pulse", {31'd0, o_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        checks      = 0;
        errors      = 0;
        model_regs  = 32'd0;
        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_req_src   = 3'd0;
        i_req_dst   = 4'd0;
        i_bus_value = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_regs", o_reg_outputs, 32'd0);
        chk("reset_src_enable", {28'd0, o_src_enable}, 32'd0);
        chk("reset_ready", {31'd0, o_req_ready}, 32'd1);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        chk("reset_err", {31'd0, o_err}, 32'd0);

        do_xfer(3'd2, 4'b0001, 8'h00, 8'hA5, 4'b0100);
        chk("single_load", o_reg_outputs, 32'h0000_00A5);
        do_xfer(3'd0, 4'b1010, 8'h00, 8'h3C, 4'b0001);
        chk("multi_dest", o_reg_outputs, 32'h3C00_3CA5);
        do_xfer(3'd3, 4'b0100, 8'hFF, 8'h12, 4'b1000);
        chk("settle", o_reg_outputs, 32'h3C12_3CA5);

        do_reject(3'd1, 4'b0000);
        do_reject(3'd7, 4'b1111);
        do_reject(3'd4, 4'b0001);
        chk("regs_after_rejects", o_reg_outputs, 32'h3C12_3CA5);
        do_xfer(3'd1, 4'b1000, 8'h00, 8'h5E, 4'b0010);
        chk("load_after_reject", o_reg_outputs, 32'h5E12_3CA5);

        // Abort: reset lands on the LATCH edge, so nothing loads.
        i_req_valid = 1'b1;
        i_req_src   = 3'd3;
        i_req_dst   = 4'b1111;
        i_bus_value = 8'h55;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_regs = 32'd0;
        @(negedge clk);
        chk("abort_regs", o_reg_outputs, 32'd0);
        chk("abort_src_enable", {28'd0, o_src_enable}, 32'd0);
        chk("abort_ready", {31'd0, o_req_ready}, 32'd1);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        i_bus_value = 8'h00;
        repeat (4) @(negedge clk);
        chk("abort_regs_later", o_reg_outputs, 32'd0);

        // Back-to-back: reqValid held high; accepts must be 4 cycles apart.
        begin
            exp_t e;
            model_regs = apply_load(model_regs, 4'b0100, 8'h77);
            e.is_err = 1'b0;
            e.regs   = model_regs;
            sb_q.push_back(e);
            sb_q.push_back(e);
        end
        i_req_valid = 1'b1;
        i_req_src   = 3'd1;
        i_req_dst   = 4'b0100;
        i_bus_value = 8'h77;
        for (int c = 0; c < 20; c++) begin
            if (o_req_ready) acc.push_back(c);
            @(posedge clk); #1;
            if (acc.size() == 2) break;
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 32'd2);
        if (acc.size() == 2) chk("b2b_gap", acc[1] - acc[0], 32'd4);
        repeat (6) @(negedge clk);
        chk("b2b_regs", o_reg_outputs, 32'h0077_0000);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
